// File: rtl/video_pattern_source.sv
// video_pattern_source: AXI4-Stream 24-bit RGB test-frame generator.
// Emits WIDTH x HEIGHT frames (tuser = SOF, tlast = EOL) with an idle gap
// of FRAME_GAP cycles between frames; fully honours tready backpressure.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   enable              run request (sampled in IDLE and at frame-gap end)
//   pattern_sel         0 solid, 1 colour bars, 2 ramp, 3 checkerboard
//   solid_color         RGB used by pattern 0
//   m_axis_video_*      AXI4-Stream video master (tdata = {R,G,B})
//   busy                high whenever not IDLE
//   frame_cnt           completed frames, wraps at 16 bits
// Optional: define VIDEO_PATTERN_SOURCE_LINE_GAP_EN to insert LINE_GAP idle
// cycles after every line except the last of a frame.
module video_pattern_source #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int FRAME_GAP = 16,
    parameter int LINE_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    input  logic        m_axis_video_tready,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BARW = WIDTH / 8;
    localparam int BW   = (BARW > 1) ? $clog2(BARW) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BARW - 1);
    localparam logic [15:0]   FG_LAST = 16'(FRAME_GAP - 1);
    localparam logic [15:0]   LG_LAST = 16'(LINE_GAP - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FGAP   = 2'd2;
    localparam logic [1:0] S_LGAP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    bar_q, bar_d;
    logic [BW-1:0] bpx_q, bpx_d;
    logic [15:0]   gap_q, gap_d;
    logic [1:0]    pat_q, pat_d;
    logic [23:0]   solid_q, solid_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          tvalid_q, tvalid_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic [23:0]   tdata_q, tdata_d;
    logic          busy_q, busy_d;

    logic          xfer;
    logic          start;
    logic          load;
    logic [15:0]   gap_last;

    function automatic logic [23:0] pixel(
        input logic [1:0]  pat,
        input logic [23:0] solid,
        input logic [15:0] px,
        input logic [15:0] py,
        input logic [2:0]  bar
    );
        logic [23:0] p;
        p = 24'h000000;
        unique case (pat)
            2'd0: p = solid;
            2'd1: begin
                unique case (bar)
                    3'd0: p = 24'hFFFFFF;
                    3'd1: p = 24'hFFFF00;
                    3'd2: p = 24'h00FFFF;
                    3'd3: p = 24'h00FF00;
                    3'd4: p = 24'hFF00FF;
                    3'd5: p = 24'hFF0000;
                    3'd6: p = 24'h0000FF;
                    3'd7: p = 24'h000000;
                endcase
            end
            2'd2: p = {px[7:0], px[7:0], px[7:0]};
            2'd3: p = (px[3] ^ py[3]) ? 24'hFFFFFF : 24'h000000;
        endcase
        return p;
    endfunction

    // The line gap shares the gap counter; in builds without LGAP the
    // state never equals S_LGAP so only the frame terminal remains.
    assign gap_last = (state_q == S_LGAP) ? LG_LAST : FG_LAST;
    assign xfer     = tvalid_q && m_axis_video_tready;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bar_d    = bar_q;
        bpx_d    = bpx_q;
        gap_d    = gap_q;
        pat_d    = pat_q;
        solid_d  = solid_q;
        fcnt_d   = fcnt_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        start    = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) start = 1'b1;
            end
            S_ACTIVE: begin
                if (xfer) begin
                    if (x_q == X_LAST) begin
                        x_d   = '0;
                        bar_d = '0;
                        bpx_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d  = S_FGAP;
                            gap_d    = '0;
                            fcnt_d   = fcnt_q + 16'd1;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end else begin
                            y_d = y_q + 1'b1;
`ifdef VIDEO_PATTERN_SOURCE_LINE_GAP_EN
                            state_d  = S_LGAP;
                            gap_d    = '0;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
`else
                            load = 1'b1;
`endif
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        // Bar index advances every WIDTH/8 pixels.
                        if (bpx_q == B_LAST) begin
                            bpx_d = '0;
                            bar_d = bar_q + 3'd1;
                        end else begin
                            bpx_d = bpx_q + 1'b1;
                        end
                        load = 1'b1;
                    end
                end
            end
            S_FGAP: begin
                if (gap_q == gap_last) begin
                    if (enable) start = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`ifdef VIDEO_PATTERN_SOURCE_LINE_GAP_EN
            S_LGAP: begin
                if (gap_q == gap_last) begin
                    state_d = S_ACTIVE;
                    load    = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Frame start: configuration is captured only here.
        if (start) begin
            state_d = S_ACTIVE;
            pat_d   = pattern_sel;
            solid_d = solid_color;
            x_d     = '0;
            y_d     = '0;
            bar_d   = '0;
            bpx_d   = '0;
            load    = 1'b1;
        end

        // Present the pixel at the next (x, y) in the output registers.
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = pixel(pat_d, solid_d, 16'(x_d), 16'(y_d), bar_d);
            tuser_d  = (x_d == '0) && (y_d == '0);
            tlast_d  = (x_d == X_LAST);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bar_q    <= '0;
            bpx_q    <= '0;
            gap_q    <= '0;
            pat_q    <= '0;
            solid_q  <= '0;
            fcnt_q   <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            bpx_q    <= bpx_d;
            gap_q    <= gap_d;
            pat_q    <= pat_d;
            solid_q  <= solid_d;
            fcnt_q   <= fcnt_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
        end
    end

    assign m_axis_video_tdata  = tdata_q;
    assign m_axis_video_tvalid = tvalid_q;
    assign m_axis_video_tuser  = tuser_q;
    assign m_axis_video_tlast  = tlast_q;
    assign busy                = busy_q;
    assign frame_cnt           = fcnt_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: scoreboard bench for video_pattern_source.
// Reference frames are built from the pattern rules; a monitor pops them.
`timescale 1ns/1ps
module tb_video_pattern_source;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int FG = 16;
    localparam int LG = 4;
    localparam int NPIX = W * H;
`ifdef VIDEO_PATTERN_SOURCE_LINE_GAP_EN
    localparam int LG_EXP = LG;
`else
    localparam int LG_EXP = 0;
`endif

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
        logic        sol;
        logic        eof;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_color;
    logic        tready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic        busy;
    logic [15:0] frame_cnt;

    beat_t q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    exp_fc = 0;
    int    idle = 0;
    bit    run_start = 1'b0;
    bit    rand_rdy = 1'b0;
    bit    prev_stall = 1'b0;
    logic [23:0] pd;
    logic        pu;
    logic        pl;

    video_pattern_source #(
        .WIDTH(W), .HEIGHT(H), .FRAME_GAP(FG), .LINE_GAP(LG)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .pattern_sel         (pattern_sel),
        .solid_color         (solid_color),
        .m_axis_video_tready (tready),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .busy                (busy),
        .frame_cnt           (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int pat,
        input logic [23:0] sol, input int x, input int y);
        logic [7:0] r;
        r = x[7:0];
        case (pat)
            0: return sol;
            1: case (x / (W / 8))
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            2: return {r, r, r};
            default: return (((x / 8) % 2) != ((y / 8) % 2))
                            ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [23:0] sol);
        beat_t b;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                b.d   = ref_pix(pat, sol, x, y);
                b.u   = (x == 0 && y == 0);
                b.l   = (x == W - 1);
                b.sol = (x == 0);
                b.eof = (x == W - 1 && y == H - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Random sink backpressure.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: stall stability, gaps, and scoreboard compare.
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            chk("stall_tvalid", {31'd0, tvalid}, 1);
            chk("stall_tdata", {8'd0, tdata}, {8'd0, pd});
            chk("stall_side", {30'd0, tuser, tlast}, {30'd0, pu, pl});
        end
        if (tvalid) begin
            if (tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, tvalid}, 0);
                end else begin
                    e = q.pop_front();
                    chk("tdata", {8'd0, tdata}, {8'd0, e.d});
                    chk("tuser", {31'd0, tuser}, {31'd0, e.u});
                    chk("tlast", {31'd0, tlast}, {31'd0, e.l});
                    if (e.u) begin
                        chk("frame_cnt_sof", {16'd0, frame_cnt}, exp_fc);
                        if (run_start) run_start = 1'b0;
                        else chk("frame_gap", idle, FG);
                    end else if (e.sol) begin
                        chk("line_gap", idle, LG_EXP);
                    end
                    if (e.eof) exp_fc = (exp_fc + 1) % 65536;
                end
                idle = 0;
            end
        end else begin
            idle++;
        end
        prev_stall = tvalid && !tready && !rst;
        pd = tdata;
        pu = tuser;
        pl = tlast;
    end

    task automatic run(input int p0, input logic [23:0] s0,
                       input int p1, input logic [23:0] s1,
                       input int n, input int drop);
        bit chg;
        int c;
        chg = 1'b0;
        pattern_sel = 2'(p0);
        solid_color = s0;
        push_frame(p0, s0);
        for (int i = 1; i < n; i++) push_frame(p1, s1);
        run_start = 1'b1;
        enable = 1'b1;
        cyc();
        chk("start_tvalid", {31'd0, tvalid}, 1);
        chk("start_tuser", {31'd0, tuser}, 1);
        chk("start_busy", {31'd0, busy}, 1);
        c = 0;
        while (!(q.size() == 0 && !busy) && c < 6000) begin
            if (!chg && q.size() <= NPIX * n - 10) begin
                pattern_sel = 2'(p1);
                solid_color = s1;
                chg = 1'b1;
            end
            if (q.size() <= NPIX - drop) enable = 1'b0;
            cyc();
            c++;
        end
        chk("run_done", {31'd0, (q.size() == 0 && !busy)}, 1);
        chk("frame_cnt_end", {16'd0, frame_cnt}, exp_fc);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_tvalid", {31'd0, tvalid}, 0);
        end
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int rp0;
        int rp1;
        rst = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd1;
        solid_color = 24'h0;
        repeat (3) cyc();
        chk("rst_tvalid", {31'd0, tvalid}, 0);
        chk("rst_tuser", {31'd0, tuser}, 0);
        chk("rst_tlast", {31'd0, tlast}, 0);
        chk("rst_tdata", {8'd0, tdata}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        rst = 1'b0;
        repeat (2) cyc();
        chk("idle_no_enable", {31'd0, tvalid | busy}, 0);

        // Colour bars, full throughput, two frames back to back.
        run(1, 24'h0, 1, 24'h0, 2, 1);

        // Same under random backpressure.
        rand_rdy = 1'b1;
        run(1, 24'h0, 1, 24'h0, 2, 1);
        run(3, 24'h0, 2, 24'h0, 2, 1);
        rand_rdy = 1'b0;

        // Mid-frame config change only takes effect next frame.
        run(0, 24'h123456, 0, 24'hABCDEF, 2, 1);

        // Enable dropped at pixel 20: frame still completes.
        run(2, 24'h0, 2, 24'h0, 1, 20);

        // Reset at pixel 30.
        pattern_sel = 2'd3;
        enable = 1'b1;
        push_frame(3, 24'h0);
        run_start = 1'b1;
        c = 0;
        while (q.size() > NPIX - 30 && c < 500) begin
            cyc();
            c++;
        end
        chk("reached_pix30", {31'd0, (q.size() <= NPIX - 30)}, 1);
        rst = 1'b1;
        enable = 1'b0;
        cyc();
        chk("midrst_tvalid", {31'd0, tvalid}, 0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        q.delete();
        exp_fc = 0;
        cyc();
        rst = 1'b0;
        run(3, 24'h0, 3, 24'h0, 1, 1);

        // Randomised patterns and colours under backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rp0 = int'($urandom_range(0, 3));
            rp1 = int'($urandom_range(0, 3));
            run(rp0, 24'($urandom), rp1, 24'($urandom), 2, 1);
        end
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
